// File: rtl/spi_pkg.sv
// Shared types and defaults for the Mode 0 SPI slave.
package spi_pkg;

    localparam int DATA_WIDTH_DEFAULT  = 8;
    localparam int SYNC_STAGES_DEFAULT = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_slave_state_e;

    // Reserved for future CPOL/CPHA support; only MODE0 is implemented.
    typedef enum logic [1:0] {
        MODE0 = 2'd0,
        MODE1 = 2'd1,
        MODE2 = 2'd2,
        MODE3 = 2'd3
    } spi_mode_e;

endpackage

// File: rtl/spi_slave_if.sv
// SPI pins plus the local TX/RX word handshake of the slave.
interface spi_slave_if
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
);
    logic                  sclk_i;
    logic                  ss_ni;
    logic                  mosi_i;
    logic                  miso_o;
    logic [DATA_WIDTH-1:0] tx_data_i;
    logic                  tx_load_i;
    logic                  tx_taken_tick_o;
    logic [DATA_WIDTH-1:0] rx_data_o;
    logic                  rx_done_tick_o;
    logic                  busy_o;

    modport slave (
        input  sclk_i, ss_ni, mosi_i, tx_data_i, tx_load_i,
        output miso_o, tx_taken_tick_o, rx_data_o, rx_done_tick_o, busy_o
    );

    modport master (
        output sclk_i, ss_ni, mosi_i, tx_data_i, tx_load_i,
        input  miso_o, tx_taken_tick_o, rx_data_o, rx_done_tick_o, busy_o
    );
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for one asynchronous bit with rise/fall ticks.
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Shift the pin through the synchronizer chain and keep one delayed copy for edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_slave.sv
// Mode 0 (CPOL=0, CPHA=0, MSB first) SPI slave oversampled by clk_i.
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEFAULT,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    spi_slave_if.slave bus
);
    localparam int                CNT_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0]  CNT_WORD = CNT_W'(DATA_WIDTH);

    spi_slave_state_e      state;
    logic [DATA_WIDTH-1:0] tx_buf;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  miso_q;
    logic [DATA_WIDTH-1:0] rx_data_q;
    logic                  rx_done_q;
    logic                  tx_taken_q;
    logic                  busy_q;

    logic sclk_rise, sclk_fall, sclk_level_unused;
    logic ss_rise, ss_fall, ss_level_unused;
    logic mosi_level, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk_i(clk_i), .rst_ni(rst_ni), .async_in(bus.sclk_i),
        .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ss (
        .clk_i(clk_i), .rst_ni(rst_ni), .async_in(bus.ss_ni),
        .level(ss_level_unused), .rise(ss_rise), .fall(ss_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk_i(clk_i), .rst_ni(rst_ni), .async_in(bus.mosi_i),
        .level(mosi_level), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    // Frame FSM with TX buffer, shift registers, bit counter and registered outputs.
    // Select edges are tested before SCLK edges so a coincident SCLK edge is dropped.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            tx_buf     <= '0;
            tx_shift   <= '0;
            rx_shift   <= '0;
            bit_cnt    <= '0;
            miso_q     <= 1'b0;
            rx_data_q  <= '0;
            rx_done_q  <= 1'b0;
            tx_taken_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            rx_done_q  <= 1'b0;
            tx_taken_q <= 1'b0;
            // A same-cycle copy below still reads the old buffer value.
            if (bus.tx_load_i) begin
                tx_buf <= bus.tx_data_i;
            end
            case (state)
                IDLE: begin
                    if (ss_fall) begin
                        state      <= ACTIVE;
                        busy_q     <= 1'b1;
                        tx_shift   <= tx_buf;
                        tx_taken_q <= 1'b1;
                        bit_cnt    <= '0;
                        miso_q     <= tx_buf[DATA_WIDTH-1];
                    end
                end
                ACTIVE: begin
                    if (ss_rise) begin
                        state   <= IDLE;
                        busy_q  <= 1'b0;
                        bit_cnt <= '0;
                        miso_q  <= 1'b0;
                    end else begin
                        if (bit_cnt == CNT_WORD) begin
                            rx_data_q <= rx_shift;
                            rx_done_q <= 1'b1;
                            bit_cnt   <= '0;
                        end
                        if (sclk_rise) begin
                            rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_level};
                            bit_cnt  <= bit_cnt + CNT_W'(1);
                        end
                        // A fall with the counter at a word boundary starts the next word.
                        if (sclk_fall) begin
                            if (bit_cnt == '0 || bit_cnt == CNT_WORD) begin
                                tx_shift   <= tx_buf;
                                tx_taken_q <= 1'b1;
                                miso_q     <= tx_buf[DATA_WIDTH-1];
                            end else begin
                                tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
                                miso_q   <= tx_shift[DATA_WIDTH-2];
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.miso_o          = miso_q;
    assign bus.rx_data_o       = rx_data_q;
    assign bus.rx_done_tick_o  = rx_done_q;
    assign bus.tx_taken_tick_o = tx_taken_q;
    assign bus.busy_o          = busy_q;

endmodule
